// File: rtl/imem_program_encoder_if.sv
// Field-level instruction input and imem write-port bundle for imem_program_encoder.
interface imem_program_encoder_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err_illegal;
    logic              err_overflow;

    // Source side: drives instruction fields, observes the write port and status
    modport master (
        output start, in_valid, in_last, in_kind, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7b5, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, count,
               err_illegal, err_overflow
    );

    // Encoder side
    modport slave (
        input  start, in_valid, in_last, in_kind, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7b5, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, count,
               err_illegal, err_overflow
    );
endinterface

// File: rtl/imem_program_encoder.sv
// Encodes RV32I field descriptions (R, I-ALU, LOAD, STORE, BRANCH, JAL) into
// machine words and writes them sequentially into instruction memory.
module imem_program_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    imem_program_encoder_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CAPACITY = CNT_W'(2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       NOP_WORD = 32'h0000_0013;

    localparam logic [2:0] K_R      = 3'd0;
    localparam logic [2:0] K_IALU   = 3'd1;
    localparam logic [2:0] K_LOAD   = 3'd2;
    localparam logic [2:0] K_STORE  = 3'd3;
    localparam logic [2:0] K_BRANCH = 3'd4;
    localparam logic [2:0] K_JAL    = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              in_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_illegal_q;
    logic              err_overflow_q;

    logic [31:0] imm;
    logic [31:0] word_c;
    logic        bad_c;
    logic        accept_c;
    logic        full_c;
    logic        unused_imm_hi;

    assign imm           = bus.in_imm;
    assign unused_imm_hi = ^imm[31:21];
    assign accept_c      = bus.in_valid & in_ready_q;
    assign full_c        = (count_q == CAPACITY);

    // Combinational field-to-word encoder; flags illegal kinds and odd branch/jump offsets
    always_comb begin
        word_c = NOP_WORD;
        bad_c  = 1'b0;
        case (bus.in_kind)
            K_R:      word_c = {1'b0, bus.in_funct7b5, 5'b0, bus.in_rs2, bus.in_rs1,
                                bus.in_funct3, bus.in_rd, 7'b0110011};
            K_IALU:   word_c = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
            K_LOAD:   word_c = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011};
            K_STORE:  word_c = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                imm[4:0], 7'b0100011};
            K_BRANCH: begin
                word_c = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          imm[4:1], imm[11], 7'b1100011};
                bad_c  = imm[0];
            end
            K_JAL: begin
                word_c = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
                bad_c  = imm[0];
            end
            default: begin
                word_c = NOP_WORD;
                bad_c  = 1'b1;
            end
        endcase
    end

    // Session FSM, write pointer, registered imem write port and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= BASE;
            count_q        <= '0;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE;
            imem_wdata_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q        <= S_LOAD;
                        ptr_q          <= BASE;
                        count_q        <= '0;
                        in_ready_q     <= 1'b1;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        err_illegal_q  <= 1'b0;
                        err_overflow_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept_c) begin
                        // Pointer and count advance at accept so back-to-back full checks stay exact
                        if (!full_c) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= ptr_q;
                            imem_wdata_q <= word_c;
                            ptr_q        <= ptr_q + ADDR_W'(1);
                            count_q      <= count_q + CNT_W'(1);
                        end else begin
                            err_overflow_q <= 1'b1;
                        end
                        if (bad_c) begin
                            err_illegal_q <= 1'b1;
                        end
                        if (bus.in_last) begin
                            state_q    <= S_FLUSH;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = imem_addr_q;
    assign bus.imem_wdata   = imem_wdata_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.count        = count_q;
    assign bus.err_illegal  = err_illegal_q;
    assign bus.err_overflow = err_overflow_q;

endmodule

// File: tb/tb_imem_program_encoder.sv
// Scoreboard bench for imem_program_encoder: expected writes are queued at drive
// time and checked against the imem write port as they appear.
module tb_imem_program_encoder;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CAP    = 1 << ADDR_W;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];
    int   exp_ptr = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    imem_program_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    imem_program_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write-port monitor: every write must match the oldest queued expectation
    always @(negedge clk) begin
        wr_t e;
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_we", 32'(bus.imem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 32'(bus.imem_addr), e.addr);
                chk("wdata", bus.imem_wdata, e.word);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_ptr   = 0;
        exp_cnt   = 0;
    endtask

    task automatic send(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                        input logic [31:0] imm, input logic last, input logic [31:0] w);
        bus.in_kind     = kind;
        bus.in_rd       = rd;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7b5;
        bus.in_imm      = imm;
        bus.in_last     = last;
        bus.in_valid    = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'd1);
        if (exp_cnt < CAP) begin
            exp_q.push_back('{addr: 32'(exp_ptr), word: w});
            exp_ptr = (exp_ptr + 1) % CAP;
            exp_cnt++;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the accept of the last instruction: one FLUSH cycle, then DONE
    task automatic finish_session(input logic ill, input logic ovf);
        chk("flush_busy", 32'(bus.busy), 32'd1);
        chk("flush_done", 32'(bus.done), 32'd0);
        tick();
        chk("done", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_ready", 32'(bus.in_ready), 32'd0);
        chk("count", 32'(bus.count), 32'(exp_cnt));
        chk("err_illegal", 32'(bus.err_illegal), 32'(ill));
        chk("err_overflow", 32'(bus.err_overflow), 32'(ovf));
        chk("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_ill"}, 32'(bus.err_illegal), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.err_overflow), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
        bus.in_kind     = '0;
        bus.in_rd       = '0;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.in_funct3   = '0;
        bus.in_funct7b5 = 1'b0;
        bus.in_imm      = '0;
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();

        // add x3,x1,x2
        start_session();
        chk("start_busy", 32'(bus.busy), 32'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3);
        finish_session(1'b0, 1'b0);

        // sub, sw, lw back-to-back
        start_session();
        chk("restart_done", 32'(bus.done), 32'd0);
        chk("restart_count", 32'(bus.count), 32'd0);
        send(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 32'd0, 1'b0, 32'h407302B3);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b0, 32'h0020A423);
        send(3'd2, 5'd4, 5'd2, 5'd0, 3'd2, 1'b0, 32'd12, 1'b1, 32'h00C12203);
        finish_session(1'b0, 1'b0);

        // beq x0,x0,-4 ; jal x1,+2048
        start_session();
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'hFE000EE3);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0800, 1'b1, 32'h001000EF);
        finish_session(1'b0, 1'b0);

        // illegal kind, then branch with odd offset
        start_session();
        send(3'd7, 5'd9, 5'd9, 5'd9, 3'd7, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h00000013);
        chk("ill_sticky", 32'(bus.err_illegal), 32'd1);
        send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3, 1'b1, 32'h00000163);
        finish_session(1'b1, 1'b0);
        tick();
        chk("ill_held", 32'(bus.err_illegal), 32'd1);

        // five addi into a four-word memory
        start_session();
        chk("clr_ill", 32'(bus.err_illegal), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(k), logic'(k == 5),
                 (32'(k) << 20) | 32'h93);
        end
        finish_session(1'b0, 1'b1);

        // reset one cycle after an accept drops the pending write
        start_session();
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0, 32'h00000013);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk_all_zero("abort");
        tick();
        chk_all_zero("abort2");
        reset = 1'b0;
        tick();
        start_session();
        chk("post_rst_count", 32'(bus.count), 32'd0);
        chk("post_rst_ill", 32'(bus.err_illegal), 32'd0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3);
        finish_session(1'b0, 1'b0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_program_encoder.md
Name: imem_program_encoder

Overview:
Encodes field-level instruction descriptions into 32-bit RV32I machine words and writes them sequentially into instruction memory. It is the encoding counterpart of the opcode decoder and covers the same instruction classes: R, I-ALU, load, store, branch and jal. It sits between the testbench or boot-loader source and the imem write port. It reports done when the program image is complete, so core reset can be released.

Parameters:
ADDR_W, 6, imem word-address width; capacity is 2**ADDR_W words
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a load session
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept fields this cycle
in_last  input  1  marks the final instruction of the session
in_kind  input  3  instruction class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6-7 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3 field
in_funct7b5  input  1  instruction bit 30 (R-type only)
in_imm  input  32  sign-extended immediate; byte offset for BRANCH/JAL
imem_we  output  1  imem write enable
imem_addr  output  ADDR_W  imem word address
imem_wdata  output  32  encoded instruction word
busy  output  1  session in progress
done  output  1  session complete; held until the next start
count  output  ADDR_W+1  number of words written this session
err_illegal  output  1  sticky: illegal kind, or BRANCH/JAL with in_imm[0]=1
err_overflow  output  1  sticky: instruction accepted while imem was full

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; imem_addr = BASE_ADDR; write pointer = BASE_ADDR.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE or DONE + start -> LOAD. Entering LOAD clears count, err_*, done; pointer = BASE_ADDR.
  - LOAD + accept with in_last=1 -> FLUSH.
  - FLUSH -> DONE after exactly one cycle.
  - start is ignored in LOAD and FLUSH.
- in_ready = 1 only in LOAD. Accept = in_valid & in_ready. Throughput is 1 instruction per cycle.
- Encoding is combinational from the input fields. The result is registered at accept. imem_we = 1 in the following cycle with imem_addr = pointer and imem_wdata = the word. The write commits at the next edge. Latency is accept edge +1.
- After each write, pointer increments and count increments. busy = 1 in LOAD and FLUSH. done = 1 in DONE.
- imem_we is a single-cycle pulse per accepted in-range instruction. It is 0 in IDLE and DONE unless the final write from FLUSH is in progress.
- Encodings, listed as fields from bit 31 down to bit 0:
  - R: {1'b0, funct7b5, 5'b0, rs2, rs1, f3, rd, 0110011}
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}
  - LOAD: {imm[11:0], rs1, f3, rd, 0000011}
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
- Immediate bits above each field are ignored. No range check is performed.
- Illegal kind (6 or 7): the word is written as the NOP 0x00000013 and err_illegal is set. The pointer advances normally.
- BRANCH/JAL with imm[0]=1: encoded normally (bit 0 dropped) and err_illegal is set.
- Overflow: an accept when count == 2**ADDR_W is still accepted (in_ready stays 1). No write occurs, count is unchanged, and err_overflow is set. in_last on a discarded instruction still moves the FSM to FLUSH; FLUSH then performs no write.
- Pointer wraps modulo 2**ADDR_W. With BASE_ADDR != 0, wrap occurs below capacity and is legal.
- Reset mid-session aborts immediately. A pending write is dropped and imem_we is 0 from reset assertion onward.
- start coincident with reset: reset wins.

Test Plan:
- add x3,x1,x2 (kind 0, rd 3, rs1 1, rs2 2, f3 0, f7b5 0, last) -> imem_we at addr 0, wdata 0x002081B3; done 2 cycles after accept; count 1.
- Back-to-back, in_valid held: sub x5,x6,x7 (f7b5 1), then sw x2,8(x1) (kind 3, f3 010, imm 8) -> consecutive writes 0x407302B3 at addr 0 and 0x0020A423 at addr 1; no bubbles.
- beq x0,x0,-4 (kind 4, imm 0xFFFFFFFC), then jal x1,+2048 (kind 5, rd 1, imm 0x800) -> 0xFE000EE3 and 0x001000EF.
- Kind 7, then a branch with imm 3 -> first word 0x00000013; err_illegal = 1 and stays set until the next start.
- ADDR_W=2: five instructions, last on the 5th -> four writes to addr 0-3; 5th not written; err_overflow = 1; count = 4; done = 1.
- Assert reset one cycle after an accept -> no imem_we; all outputs 0. A new start then writes from BASE_ADDR with count 0 and flags clear.
